memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 37 +++
 rtl/memory_arbiter_rr_select.sv | 35 +++
 rtl/memory_arbiter.sv | 169 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types, constants and request-kind priority helper for the memory arbiter.
package memory_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IREQ   = 2'd0,
    DREQ_R = 2'd1,
    DREQ_W = 2'd2
  } req_kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Data writes beat data reads beat instruction fetches within one CPU.
  function automatic req_kind_t pick_kind(input logic i_dren, input logic i_dwen);
    req_kind_t v_kind;
    if (i_dwen) begin
      v_kind = DREQ_W;
    end else if (i_dren) begin
      v_kind = DREQ_R;
    end else begin
      v_kind = IREQ;
    end
    return v_kind;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after the start pointer.
module memory_arbiter_rr_select #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_start,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  logic [N-1:0] w_rot;
  int           w_cand;

  // Rotate so bit 0 is the start position, then take the lowest set bit.
  always_comb begin
    w_rot   = N'({i_req, i_req} >> i_start);
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && w_rot[i]) begin
        w_cand = int'(i_start) + i;
        if (w_cand >= N) begin
          w_cand = w_cand - N;
        end else begin
          w_cand = w_cand;
        end
        o_idx   = PTR_W'(w_cand);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates per-CPU icache/dcache requests onto a single RAM port, one
// transaction at a time, round-robin across CPUs.
module memory_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = memory_arbiter_pkg::WORD_W
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  import memory_arbiter_pkg::*;

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_rr_next;
  logic [PTR_W-1:0] r_cpu;
  req_kind_t        r_kind;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;

  logic [CPUS-1:0]   w_any_req;
  logic [PTR_W-1:0]  w_sel_idx;
  logic              w_sel_valid;
  req_kind_t         w_sel_kind;
  logic [WORD_W-1:0] w_sel_addr;
  logic [WORD_W-1:0] w_sel_data;
  logic              w_gnt_active;
  logic              w_latch;
  logic              w_done;

  assign w_any_req = iREN | dREN | dWEN;
  assign w_rr_next = (r_cpu == PTR_W'(CPUS - 1)) ? '0 : r_cpu + PTR_W'(1);

  memory_arbiter_rr_select #(
    .N     (CPUS),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .i_req   (w_any_req),
    .i_start (r_rr_ptr),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  // Kind, address and write data of the CPU the picker chose.
  always_comb begin
    w_sel_kind = IREQ;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (w_sel_idx == PTR_W'(c)) begin
        w_sel_kind = pick_kind(dREN[c], dWEN[c]);
        w_sel_addr = (w_sel_kind == IREQ) ? iaddr[c*WORD_W +: WORD_W]
                                          : daddr[c*WORD_W +: WORD_W];
        w_sel_data = (w_sel_kind == DREQ_W) ? dstore[c*WORD_W +: WORD_W] : '0;
      end
    end
  end

  // A dropped request line of the granted kind aborts the transaction.
  always_comb begin
    w_gnt_active = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      if (r_cpu == PTR_W'(c)) begin
        case (r_kind)
          IREQ:    w_gnt_active = iREN[c];
          DREQ_R:  w_gnt_active = dREN[c];
          DREQ_W:  w_gnt_active = dWEN[c];
          default: w_gnt_active = 1'b0;
        endcase
      end
    end
  end

  // Next-state logic and RAM/CPU outputs.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_done       = 1'b0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = '1;
    dwait        = '1;
    iload        = '0;
    dload        = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_latch      = 1'b1;
          w_next_state = ST_BUSY;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!w_gnt_active) begin
          w_next_state = ST_IDLE;
        end else begin
          ramREN   = (r_kind != DREQ_W);
          ramWEN   = (r_kind == DREQ_W);
          ramaddr  = r_addr;
          ramstore = r_data;
          if (ramstate_t'(ramstate) == ACCESS) begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
            for (int c = 0; c < CPUS; c++) begin
              if (r_cpu == PTR_W'(c)) begin
                if (r_kind == IREQ) begin
                  iwait[c]                   = 1'b0;
                  iload[c*WORD_W +: WORD_W]  = ramload;
                end else begin
                  dwait[c]                   = 1'b0;
                  dload[c*WORD_W +: WORD_W]  = ramload;
                end
              end
            end
          end else begin
            w_next_state = ST_BUSY;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and latched grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_cpu    <= '0;
      r_kind   <= IREQ;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_cpu  <= w_sel_idx;
        r_kind <= w_sel_kind;
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
      end
      if (w_done) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic              CLK;
  logic              nRST;
  logic [CPUS-1:0]   iREN, dREN, dWEN;
  logic [CPUS*W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]   iwait, dwait;
  logic [CPUS*W-1:0] iload, dload;
  logic              ramREN, ramWEN;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  int n_checks = 0;
  int n_errors = 0;

  // Model: one outstanding transaction (kind 0=ifetch, 1=dread, 2=dwrite).
  bit          m_busy, n_busy;
  int          m_cpu, n_cpu, m_kind, n_kind, m_rr, n_rr;
  logic [W-1:0] m_addr, n_addr, m_data, n_data;
  logic [CPUS-1:0]   e_iwait, e_dwait;
  logic [CPUS*W-1:0] e_iload, e_dload;
  logic              e_ren, e_wen;
  logic [W-1:0]      e_addr, e_store;
  int done_log[$];

  memory_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_iwait"}, 64'(iwait), 64'(2'b11));
    check_value({tag, "_dwait"}, 64'(dwait), 64'(2'b11));
    check_value({tag, "_iload"}, iload, 64'd0);
    check_value({tag, "_dload"}, dload, 64'd0);
    check_value({tag, "_strobes"}, {62'd0, ramREN, ramWEN}, 64'd0);
    check_value({tag, "_ramaddr"}, 64'(ramaddr), 64'd0);
    check_value({tag, "_ramstore"}, 64'(ramstore), 64'd0);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_cpu = 0; m_kind = 0; m_rr = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_eval();
    bit still;
    int c;
    e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    n_busy = m_busy; n_cpu = m_cpu; n_kind = m_kind; n_rr = m_rr;
    n_addr = m_addr; n_data = m_data;
    if (m_busy) begin
      still = (m_kind == 0) ? iREN[m_cpu] : (m_kind == 1) ? dREN[m_cpu] : dWEN[m_cpu];
      if (!still) begin
        n_busy = 1'b0;
      end else begin
        e_ren = (m_kind != 2); e_wen = (m_kind == 2);
        e_addr = m_addr; e_store = (m_kind == 2) ? m_data : '0;
        if (ramstate == 2'd2) begin
          if (m_kind == 0) begin
            e_iwait[m_cpu] = 1'b0; e_iload[m_cpu*W +: W] = ramload;
          end else begin
            e_dwait[m_cpu] = 1'b0; e_dload[m_cpu*W +: W] = ramload;
          end
          n_busy = 1'b0;
          n_rr = (m_cpu + 1) % CPUS;
          done_log.push_back(m_cpu);
        end
      end
    end else begin
      for (int k = 0; k < CPUS; k++) begin
        c = (m_rr + k) % CPUS;
        if (!n_busy && (iREN[c] || dREN[c] || dWEN[c])) begin
          n_busy = 1'b1; n_cpu = c;
          n_kind = dWEN[c] ? 2 : (dREN[c] ? 1 : 0);
          n_addr = (n_kind == 0) ? iaddr[c*W +: W] : daddr[c*W +: W];
          n_data = dstore[c*W +: W];
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_eval();
    check_value("iwait", 64'(iwait), 64'(e_iwait));
    check_value("dwait", 64'(dwait), 64'(e_dwait));
    check_value("iload", iload, e_iload);
    check_value("dload", dload, e_dload);
    check_value("ramREN", 64'(ramREN), 64'(e_ren));
    check_value("ramWEN", 64'(ramWEN), 64'(e_wen));
    check_value("ramaddr", 64'(ramaddr), 64'(e_addr));
    check_value("ramstore", 64'(ramstore), 64'(e_store));
    @(posedge CLK);
    m_busy = n_busy; m_cpu = n_cpu; m_kind = n_kind; m_rr = n_rr;
    m_addr = n_addr; m_data = n_data;
    #1;
  endtask

  task automatic drive_idle();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
  endtask

  task automatic apply_reset(input string tag);
    nRST = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs(tag);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
    done_log.delete();
  endtask

  initial begin
    apply_reset("reset");

    // Single icache read with two BUSY cycles before ACCESS.
    iREN[0] = 1'b1; iaddr[0*W +: W] = 32'h100;
    tick();
    ramstate = 2'd1;
    #1 check_value("r032_ren_b1", 64'(ramREN), 64'd1);
    tick();
    #1 check_value("r032_ren_b2", 64'(ramREN), 64'd1);
    tick();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #1 check_value("r032_iwait0", 64'(iwait[0]), 64'd0);
    check_value("r032_iload0", 64'(iload[0*W +: W]), 64'hDEADBEEF);
    tick();
    iREN[0] = 1'b0;
    #1 check_value("r032_iwait_after", 64'(iwait[0]), 64'd1);
    tick();

    // dWEN outranks iREN on the same CPU.
    iREN[0] = 1'b1; iaddr[0*W +: W] = 32'h300;
    dWEN[0] = 1'b1; daddr[0*W +: W] = 32'h200; dstore[0*W +: W] = 32'h5;
    ramstate = 2'd2;
    tick();
    #1 check_value("r033_wen", 64'(ramWEN), 64'd1);
    check_value("r033_addr", 64'(ramaddr), 64'h200);
    check_value("r033_store", 64'(ramstore), 64'h5);
    check_value("r033_iwait", 64'(iwait[0]), 64'd1);
    tick();
    dWEN[0] = 1'b0;
    tick();
    #1 check_value("r033_iren", 64'(ramREN), 64'd1);
    check_value("r033_iaddr", 64'(ramaddr), 64'h300);
    tick();
    drive_idle();
    tick();

    // Both CPUs hold dREN: completions alternate.
    apply_reset("reset2");
    dREN = 2'b11; daddr = {32'h1111, 32'h2222}; ramstate = 2'd2;
    for (int i = 0; i < 8; i++) tick();
    check_value("r034_count", 64'(done_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < done_log.size()) check_value("r034_order", 64'(done_log[i]), 64'(i % 2));
    end
    drive_idle();

    // Abort on CPU1 leaves rr pointer at 1.
    apply_reset("reset3");
    dREN[0] = 1'b1; daddr[0*W +: W] = 32'h500; ramstate = 2'd2;
    tick();
    tick();
    dREN[0] = 1'b0; ramstate = 2'd0;
    dREN[1] = 1'b1; daddr[1*W +: W] = 32'h600;
    tick();
    ramstate = 2'd1;
    tick();
    dREN[1] = 1'b0;
    #1 check_value("r035_ren", 64'(ramREN), 64'd0);
    check_value("r035_dwait1", 64'(dwait[1]), 64'd1);
    tick();
    dREN = 2'b11;
    tick();
    #1 check_value("r035_rr_kept", 64'(ramaddr), 64'h600);
    ramstate = 2'd2;
    tick();
    drive_idle();
    tick();

    // ERROR retried three times before ACCESS.
    apply_reset("reset4");
    dREN[0] = 1'b1; daddr[0*W +: W] = 32'h700;
    tick();
    ramstate = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1 check_value("r036_ren_err", 64'(ramREN), 64'd1);
      check_value("r036_dwait_err", 64'(dwait[0]), 64'd1);
      tick();
    end
    ramstate = 2'd2; ramload = 32'hCAFE0001;
    #1 check_value("r036_ren_acc", 64'(ramREN), 64'd1);
    tick();
    drive_idle();
    tick();
    check_value("r036_done", 64'(done_log.size()), 64'd1);

    // Reset during BUSY abandons the transaction.
    apply_reset("reset5");
    iREN[1] = 1'b1; iaddr[1*W +: W] = 32'h900;
    tick();
    ramstate = 2'd1;
    tick();
    ramstate = 2'd2; ramload = 32'h12345678;
    #1 nRST = 1'b0;
    #1 check_reset_outputs("r037_async");
    @(posedge CLK);
    #1 check_reset_outputs("r037_hold");
    nRST = 1'b1;
    model_reset();
    check_value("r037_no_done", 64'(done_log.size()), 64'd0);
    iREN[0] = 1'b1; iaddr[0*W +: W] = 32'h400;
    tick();
    #1 check_value("r037_first", 64'(ramaddr), 64'h400);
    tick();
    drive_idle();
    tick();

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 5) == 0) iREN[c] = ~iREN[c];
        if ($urandom_range(0, 5) == 0) dREN[c] = ~dREN[c];
        if ($urandom_range(0, 7) == 0) dWEN[c] = ~dWEN[c];
        iaddr[c*W +: W]  = $urandom();
        daddr[c*W +: W]  = $urandom();
        dstore[c*W +: W] = $urandom();
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload  = $urandom();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
